// File: rtl/mem_req_ctrl.sv
// Memory-stage data SRAM request controller: one outstanding request, flush-safe discard of late responses.
// Build option MEM_RDATA_BYPASS_EN: loads complete combinationally in the data_ok cycle, skipping DONE.
module mem_req_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic        ex_ex_ale,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [1:0]  ex_size,
  input  logic [3:0]  ex_wstrb,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_allowin,
  output logic        mem_ready_go,
  output logic [31:0] mem_dram_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        discard_reg, discard_next;
  logic        wr_reg, wr_next;
  logic [1:0]  size_reg, size_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        needs_bus;
`ifdef MEM_RDATA_BYPASS_EN
  logic        bypass_hit;
`endif

  // Misaligned accesses never reach the bus; they retire through DONE like ALU ops.
  assign needs_bus = (ex_mem_re | ex_mem_we) & ~ex_ex_ale;

  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    wr_next      = wr_reg;
    size_next    = size_reg;
    wstrb_next   = wstrb_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    mem_allowin  = 1'b0;
    mem_ready_go = 1'b0;
`ifdef MEM_RDATA_BYPASS_EN
    bypass_hit   = 1'b0;
`endif
    case (state_reg)
      IDLE, DONE: begin
        mem_allowin  = ~flush;
        mem_ready_go = (state_reg == DONE) & ~flush;
        if (flush) begin
          state_next = IDLE;
        end else if (ex_valid) begin
          state_next = needs_bus ? REQ : DONE;
          wr_next    = ex_mem_we;
          size_next  = ex_size;
          wstrb_next = ex_wstrb;
          addr_next  = ex_addr;
          wdata_next = ex_wdata;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        // A request already on the bus cannot be retracted; mark it so its response is dropped.
        if (flush) begin
          discard_next = 1'b1;
        end
        if (data_sram_addr_ok) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          discard_next = 1'b1;
        end
        if (data_sram_data_ok) begin
          if (discard_reg | flush) begin
            discard_next = 1'b0;
            state_next   = IDLE;
          end else begin
            rdata_next = data_sram_rdata;
`ifdef MEM_RDATA_BYPASS_EN
            bypass_hit   = 1'b1;
            mem_ready_go = 1'b1;
            state_next   = IDLE;
`else
            state_next   = DONE;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      discard_reg <= 1'b0;
      wr_reg      <= 1'b0;
      size_reg    <= 2'd0;
      wstrb_reg   <= 4'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      rdata_reg   <= 32'd0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
      wr_reg      <= wr_next;
      size_reg    <= size_next;
      wstrb_reg   <= wstrb_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
    end
  end

  assign data_sram_req   = (state_reg == REQ);
  assign data_sram_wr    = wr_reg;
  assign data_sram_size  = size_reg;
  assign data_sram_wstrb = wstrb_reg;
  assign data_sram_addr  = addr_reg;
  assign data_sram_wdata = wdata_reg;

`ifdef MEM_RDATA_BYPASS_EN
  assign mem_dram_rdata = bypass_hit ? data_sram_rdata : rdata_reg;
`else
  assign mem_dram_rdata = rdata_reg;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: randomized instructions, bus timing and flushes against a
// cycle-arithmetic model; a negedge monitor checks completions and bus request fields.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_mem_re = 1'b0, ex_mem_we = 1'b0, ex_ex_ale = 1'b0;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic [1:0]  ex_size = 2'd0;
  logic [3:0]  ex_wstrb = 4'd0;
  logic        flush = 1'b0;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = 32'd0;
  logic        mem_allowin, mem_ready_go;
  logic [31:0] mem_dram_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int txn_id = 0;

  typedef struct {
    int          id;
    int          cyc;
    bit          is_load;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          exp_req = 1'b0;
  logic [70:0] exp_bus = '0;
  logic [70:0] got_bus;

  mem_req_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_ex_ale(ex_ex_ale),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_size(ex_size), .ex_wstrb(ex_wstrb),
    .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_allowin(mem_allowin), .mem_ready_go(mem_ready_go), .mem_dram_rdata(mem_dram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT reports completion, checks bus request each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL ready_go_missing id=%0d got=0 required=1 at cycle %0d", exp_q[0].id, exp_q[0].cyc);
        mon_e = exp_q.pop_front();
      end
      if (mem_ready_go) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ready_go_spurious got=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc) begin
            failures++;
            $display("FAIL ready_go_cycle id=%0d got=%0d required=%0d", mon_e.id, cyc, mon_e.cyc);
          end
          if (mon_e.is_load) begin
            checks++;
            if (mem_dram_rdata !== mon_e.rdata) begin
              failures++;
              $display("FAIL load_rdata id=%0d got=%h required=%h", mon_e.id, mem_dram_rdata, mon_e.rdata);
            end
          end
        end
      end
      checks++;
      if (data_sram_req !== exp_req) begin
        failures++;
        $display("FAIL sram_req cycle=%0d got=%b required=%b", cyc, data_sram_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        got_bus = {data_sram_addr, data_sram_wdata, data_sram_size, data_sram_wstrb, data_sram_wr};
        if (got_bus !== exp_bus) begin
          failures++;
          $display("FAIL sram_fields cycle=%0d got=%h required=%h", cyc, got_bus, exp_bus);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    flush             = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},     32'(data_sram_req), 32'd0);
    chk({tag, "_wr"},      32'(data_sram_wr), 32'd0);
    chk({tag, "_size"},    32'(data_sram_size), 32'd0);
    chk({tag, "_wstrb"},   32'(data_sram_wstrb), 32'd0);
    chk({tag, "_addr"},    data_sram_addr, 32'd0);
    chk({tag, "_wdata"},   data_sram_wdata, 32'd0);
    chk({tag, "_rdata"},   mem_dram_rdata, 32'd0);
    chk({tag, "_readygo"}, 32'(mem_ready_go), 32'd0);
    chk({tag, "_allowin"}, 32'(mem_allowin), 32'd1);
  endtask

  // kind: 0 = non-memory, 1 = misaligned load, 2 = load, 3 = store
  task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic [3:0] wstrb, output int acc);
    int tries;
    ex_valid  = 1'b1;
    ex_mem_re = (kind == 1) || (kind == 2);
    ex_mem_we = (kind == 3);
    ex_ex_ale = (kind == 1);
    ex_addr   = addr;
    ex_wdata  = wdata;
    ex_size   = size;
    ex_wstrb  = wstrb;
    tries = 0;
    #1;
    while (!mem_allowin && tries < 20) begin
      step();
      #1;
      tries++;
    end
    if (!mem_allowin) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=allowin_0 required=allowin_1 within 20 cycles");
    end
    acc = cyc;
    step();
    ex_valid  = 1'b0;
    ex_mem_re = 1'b0;
    ex_mem_we = 1'b0;
    ex_ex_ale = 1'b0;
    ex_addr   = $urandom;
    ex_wdata  = $urandom;
  endtask

  // da: cycles of addr_ok delay in REQ; dd: idle cycles in WAIT before data_ok; flush_at: offset
  // from the first REQ cycle at which flush pulses (-1 for none).
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic [3:0] wstrb,
                         input int da, input int dd, input int flush_at, input logic [31:0] rdata);
    int   acc, last, done_off;
    bit   discard;
    logic wr_b;
    exp_t e;
    last = da + dd + 2;
`ifdef MEM_RDATA_BYPASS_EN
    done_off = da + dd + 1;
`else
    done_off = da + dd + 2;
`endif
    discard = (kind >= 2) && (flush_at >= 0) && (flush_at <= done_off);
    wr_b = (kind == 3);
    issue(kind, addr, wdata, size, wstrb, acc);
    txn_id++;
    $display("TXN id=%0d kind=%0d addr=%h accept_cycle=%0d da=%0d dd=%0d flush_at=%0d discard=%0d",
             txn_id, kind, addr, acc, da, dd, flush_at, discard);
    e.id = txn_id;
    e.rdata = rdata;
    if (kind < 2) begin
      e.cyc = acc + 1;
      e.is_load = 1'b0;
      exp_q.push_back(e);
      return;
    end
    exp_bus = {addr, wdata, size, wstrb, wr_b};
    exp_req = 1'b1;
    if (!discard) begin
      e.cyc = acc + 1 + done_off;
      e.is_load = (kind == 2);
      exp_q.push_back(e);
    end
    for (int o = 0; o <= last; o++) begin
      if (o == flush_at) flush = 1'b1;
      if (o == da) data_sram_addr_ok = 1'b1;
      if (o == da + 1 + dd) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
      end
      if (o == last) break;
      step();
      if (o == da) exp_req = 1'b0;
    end
  endtask

  // Idle cycles with occasional stray data_ok, which the controller must ignore.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = $urandom;
      end
      step();
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check_reset("init");

    run_txn(2, 32'h0000_1000, 32'h0, 2'd2, 4'hF, 0, 1, -1, 32'hDEAD_BEEF);
    run_txn(3, 32'h0000_2004, 32'h1234_5678, 2'd2, 4'hF, 2, 1, -1, 32'h0);
    run_txn(0, 32'h0000_0040, 32'h5555_AAAA, 2'd2, 4'h0, 0, 0, -1, 32'h0);
    run_txn(1, 32'h0000_0043, 32'h0, 2'd2, 4'h0, 0, 0, -1, 32'h0);
    gap(2);
    run_txn(2, 32'h0000_1100, 32'h0, 2'd2, 4'hF, 0, 2, 1, 32'h0BAD_0BAD);
    run_txn(2, 32'h0000_1104, 32'h0, 2'd2, 4'hF, 1, 0, -1, 32'h600D_600D);
    run_txn(2, 32'h0000_1200, 32'h0, 2'd1, 4'h3, 3, 1, 0, 32'h1111_2222);
    run_txn(2, 32'h0000_1300, 32'h0, 2'd0, 4'h1, 1, 1, 1, 32'h3333_4444);
    run_txn(3, 32'h0000_1304, 32'hCAFE_0000, 2'd2, 4'hF, 0, 1, 2, 32'h0);
    run_txn(2, 32'h0000_1400, 32'h0, 2'd2, 4'hF, 0, 0, 2, 32'h5555_6666);
    run_txn(2, 32'h0000_1404, 32'h0, 2'd2, 4'hF, 1, 1, -1, 32'h7777_8888);
    gap(3);

    for (int n = 0; n < 150; n++) begin
      int kind, da, dd, fa;
      kind = int'($urandom_range(0, 3));
      da   = int'($urandom_range(0, 3));
      dd   = int'($urandom_range(0, 3));
      fa   = -1;
      if (kind >= 2 && $urandom_range(0, 3) == 0) fa = int'($urandom_range(0, da + dd + 2));
      run_txn(kind, $urandom, $urandom, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
              da, dd, fa, $urandom);
      if ($urandom_range(0, 2) == 0) gap(int'($urandom_range(1, 3)));
    end

    run_txn(2, 32'h0000_1500, 32'h0, 2'd2, 4'hF, 0, 0, -1, 32'hCAFE_F00D);
    issue(3, 32'h0000_3008, 32'h9ABC_DEF0, 2'd2, 4'hF, acc);
    txn_id++;
    $display("TXN id=%0d kind=3 addr=00003008 accept_cycle=%0d reset_in_wait", txn_id, acc);
    exp_bus = {32'h0000_3008, 32'h9ABC_DEF0, 2'd2, 4'hF, 1'b1};
    exp_req = 1'b1;
    data_sram_addr_ok = 1'b1;
    step();
    exp_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset("rst_in_wait");
    gap(2);
    run_txn(2, 32'h0000_1600, 32'h0, 2'd2, 4'hF, 1, 0, -1, 32'h0F0F_0F0F);

    repeat (10) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Ports SHALL be as listed; one clock; reset is synchronous and active-high.
  clk  in  1  sole clock, all state on posedge
  rst  in  1  synchronous active-high reset
  ex_valid  in  1  EX-stage instruction valid
  ex_mem_re / ex_mem_we  in  1 each  instruction is load / store
  ex_ex_ale  in  1  address misaligned, so no bus access is made
  ex_addr  in  32  data address
  ex_wdata  in  32  store data, already byte-lane aligned
  ex_size  in  2  0=byte, 1=half, 2=word
  ex_wstrb  in  4  store byte enables
  flush  in  1  WB exception or ertn (wb_ex|wb_is_ertn)
  data_sram_req / data_sram_wr  out  1 each  request valid / write
  data_sram_size  out  2; data_sram_wstrb  out  4; data_sram_addr, data_sram_wdata  out  32
  data_sram_addr_ok, data_sram_data_ok  in  1 each; data_sram_rdata  in  32
  mem_allowin  out  1  controller accepts EX instruction this cycle
  mem_ready_go  out  1  instruction complete; MEM->WB register captures this cycle
  mem_dram_rdata  out  32  raw load data, valid while mem_ready_go=1

Function
REQ-002 States SHALL be IDLE, REQ, WAIT, DONE.
REQ-003 mem_allowin SHALL be 1 in IDLE or DONE with flush=0, and 0 otherwise; an instruction is accepted when ex_valid&mem_allowin.
REQ-004 On accept, the controller SHALL go to REQ if (ex_mem_re|ex_mem_we)&!ex_ex_ale, and to DONE otherwise; addr, wdata, size, wstrb and wr SHALL be registered at accept.
REQ-005 In REQ, data_sram_req SHALL be 1 and all request fields SHALL be held stable until addr_ok; on addr_ok the controller SHALL go to WAIT.
REQ-006 In WAIT, data_sram_req SHALL be 0; on data_ok the controller SHALL register data_sram_rdata into mem_dram_rdata and go to DONE.
REQ-007 In DONE, mem_ready_go SHALL be 1 for exactly one cycle; the controller SHALL then go to IDLE, or follow REQ-004 if a new instruction is accepted in the same cycle.
REQ-008 mem_ready_go SHALL be 0 in every state other than DONE, except as REQ-017 allows.
REQ-009 Stores SHALL also wait for data_ok before DONE, so store data_ok is never orphaned.
REQ-010 Flush in IDLE or DONE: go to IDLE, no mem_ready_go, no accept.
REQ-011 Flush in REQ: keep req asserted until addr_ok (no retraction), set discard flag, go to WAIT.
REQ-012 Flush in WAIT: set discard flag.
REQ-013 data_ok with discard flag set: clear flag, go to IDLE, mem_ready_go=0, mem_dram_rdata unchanged.
REQ-014 Flush in the same cycle as addr_ok (REQ) or data_ok (WAIT): the flush SHALL take priority; the response is discarded per REQ-011/013.
REQ-015 At most one outstanding request; data_ok in IDLE/REQ/DONE SHALL be ignored.

Reset
REQ-016 rst SHALL force IDLE, discard=0, data_sram_req=0, data_sram_wr=0, size=0, wstrb=0, addr=0, wdata=0, mem_dram_rdata=0, mem_ready_go=0; this SHALL take effect mid-transaction regardless of outstanding bus state.

Configuration
REQ-017 Macro MEM_RDATA_BYPASS_EN: when defined, data_ok in WAIT without discard SHALL assert mem_ready_go combinationally in that cycle with mem_dram_rdata=data_sram_rdata and go to IDLE, skipping DONE, for a load latency of addr_ok+data_ok cycles; when undefined, REQ-006/007 apply and add one cycle.

Verification
REQ-018 Load at 0x1000, addr_ok on cycle 1, data_ok on cycle 3 with rdata=0xDEADBEEF -> mem_ready_go=1 on cycle 4 (cycle 3 with bypass), mem_dram_rdata=0xDEADBEEF.
REQ-019 Store at 0x2004 with wstrb=0xF and wdata=0x12345678 -> req/wr/addr/wdata stable until addr_ok; mem_ready_go exactly once, after data_ok.
REQ-020 Non-memory op, then ex_ex_ale load -> no data_sram_req, mem_ready_go one cycle after each accept.
REQ-021 Flush while in WAIT, then data_ok=1 -> mem_ready_go stays 0, state IDLE, next load completes normally with its own data.
REQ-022 Flush in REQ with addr_ok delayed 3 cycles -> req held all 3 cycles, following data_ok discarded.
REQ-023 rst asserted in WAIT -> next cycle all outputs at REQ-016 values; mem_allowin=1.
